// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
// Contents: RV32I load/store funct3 codes and the LSU state encoding.
// Optional feature macro used by the importing files: MISALIGN_TRAP_EN.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Half accesses need addr[0]==0, word accesses need addr[1:0]==0.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
               ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data bus between the LSU and memory: single outstanding access with
// req/gnt request phase and rvalid response phase.
// Signals: dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata (LSU -> memory),
//          dbus_gnt, dbus_rvalid, dbus_rdata (memory -> LSU).
// Modports: master (LSU side), slave (memory side).
interface mem_stage_lsu_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_gnt, dbus_rvalid, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_gnt, dbus_rvalid, dbus_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane alignment for stores and loads.
// Inputs : funct3 (size/sign), addr_lo (byte offset), wdata (raw store data),
//          rdata (raw bus read word).
// Outputs: be (byte enables), wdata_rep (lane-replicated store data),
//          load_ext (selected and sign/zero-extended load data).
// Half and word sizes ignore the offset bits below their natural alignment.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        case (funct3)
            F3_SB: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            F3_SH: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        load_ext = rdata;
        case (funct3)
            F3_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_ext = {24'd0, byte_sel};
            F3_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_ext = {16'd0, half_sel};
            default: load_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit. Takes the MEM-stage address/data/control,
// runs one access on the data bus, aligns store lanes, extends load data,
// aborts on a bus timeout and stalls the pipeline until the access ends.
// Ports: clk, reset (async, active-high); mem_read_M, mem_write_M, funct3_M,
//        addr_M, write_data_M (MEM-stage inputs); stall_M, read_data_M,
//        bus_err_M (outputs); misalign_M (only with MISALIGN_TRAP_EN);
//        dbus (mem_stage_lsu_if.master).
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses in IDLE without touching the bus.
//
// state   | meaning
// IDLE    | no access in flight; latches bus fields when an access arrives
// REQ     | dbus_req held until gnt (or timeout)
// WAIT    | granted, waiting for rvalid (or timeout)
// DONE    | result/error presented for one cycle, pipeline released
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_M,
    input  logic        mem_write_M,
    input  logic [2:0]  funct3_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] write_data_M,
    output logic        stall_M,
    output logic [31:0] read_data_M,
    output logic        bus_err_M,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_M,
`endif
    mem_stage_lsu_if.master dbus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    lsu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic [1:0]       alo_q;
    logic             req_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;

    logic             access;
    logic             timeout_hit;
    logic [2:0]       f3_sel;
    logic [1:0]       alo_sel;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic [31:0]      load_c;

    assign access      = mem_read_M | mem_write_M;
    assign timeout_hit = (cnt == CNT_LAST);

    // One aligner serves both paths: live inputs while IDLE (store lanes),
    // latched funct3/offset afterwards (load extraction).
    assign f3_sel  = (state == ST_IDLE) ? funct3_M    : f3_q;
    assign alo_sel = (state == ST_IDLE) ? addr_M[1:0] : alo_q;

    lsu_align u_align (
        .funct3    (f3_sel),
        .addr_lo   (alo_sel),
        .wdata     (write_data_M),
        .rdata     (dbus.dbus_rdata),
        .be        (be_c),
        .wdata_rep (wdata_c),
        .load_ext  (load_c)
    );

    assign stall_M = ((state == ST_IDLE) && access) ||
                     (state == ST_REQ) || (state == ST_WAIT);

    assign dbus.dbus_req   = req_q;
    assign dbus.dbus_we    = we_q;
    assign dbus.dbus_addr  = addr_q;
    assign dbus.dbus_be    = be_q;
    assign dbus.dbus_wdata = wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            f3_q        <= 3'd0;
            alo_q       <= 2'd0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            be_q        <= 4'd0;
            wdata_q     <= 32'd0;
            read_data_M <= 32'd0;
            bus_err_M   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_M  <= 1'b0;
`endif
        end else begin
            // Pulses only live for the single DONE cycle.
            bus_err_M  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_M <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        f3_q    <= funct3_M;
                        alo_q   <= addr_M[1:0];
                        we_q    <= mem_write_M;
                        addr_q  <= {addr_M[31:2], 2'b00};
                        be_q    <= be_c;
                        wdata_q <= wdata_c;
                        cnt     <= '0;
`ifdef MISALIGN_TRAP_EN
                        if (is_misaligned(funct3_M, addr_M[1:0])) begin
                            state       <= ST_DONE;
                            misalign_M  <= 1'b1;
                            read_data_M <= 32'd0;
                        end else begin
                            state <= ST_REQ;
                            req_q <= 1'b1;
                        end
`else
                        state <= ST_REQ;
                        req_q <= 1'b1;
`endif
                    end
                end
                // A grant or response seen on the last counted cycle still wins.
                ST_REQ: begin
                    if (dbus.dbus_gnt) begin
                        state <= ST_WAIT;
                        req_q <= 1'b0;
                        cnt   <= '0;
                    end else if (timeout_hit) begin
                        state       <= ST_DONE;
                        req_q       <= 1'b0;
                        bus_err_M   <= 1'b1;
                        read_data_M <= 32'd0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (dbus.dbus_rvalid) begin
                        state       <= ST_DONE;
                        read_data_M <= we_q ? 32'd0 : load_c;
                    end else if (timeout_hit) begin
                        state       <= ST_DONE;
                        bus_err_M   <= 1'b1;
                        read_data_M <= 32'd0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: directed cases plus randomized accesses with
// random grant/response delays, checked cycle by cycle against a
// transaction-level expectation queue built by the stimulus driver.
// Honours MISALIGN_TRAP_EN when defined.
module tb_mem_stage_lsu;
    import lsu_pkg::*;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_M, mem_write_M;
    logic [2:0]  funct3_M;
    logic [31:0] addr_M, write_data_M;
    logic        stall_M;
    logic [31:0] read_data_M;
    logic        bus_err_M;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_M;
`endif
    logic        gnt, rvalid;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    mem_stage_lsu_if bus ();
    assign bus.dbus_gnt    = gnt;
    assign bus.dbus_rvalid = rvalid;
    assign bus.dbus_rdata  = rdata;

    mem_stage_lsu #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read_M   (mem_read_M),
        .mem_write_M  (mem_write_M),
        .funct3_M     (funct3_M),
        .addr_M       (addr_M),
        .write_data_M (write_data_M),
        .stall_M      (stall_M),
        .read_data_M  (read_data_M),
        .bus_err_M    (bus_err_M),
`ifdef MISALIGN_TRAP_EN
        .misalign_M   (misalign_M),
`endif
        .dbus         (bus.master)
    );

    typedef struct packed {
        logic        stall;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        done;
        logic        err;
        logic        mis;
        logic [31:0] rd;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    bit          cmp_en = 1'b0;

    int          req_cycles, stall_hi, err_pulses, mis_pulses;
    logic [31:0] last_addr, last_wdata, last_rd;
    logic [3:0]  last_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic logic [3:0] exp_be(input logic [2:0] f3, input int a);
        if (f3 == 3'd0) return 4'(1 << a);
        if (f3 == 3'd1) return 4'(3 << (a & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0) return 32'(d[7:0] * 32'h0101_0101);
        if (f3 == 3'd1) return 32'(d[15:0] * 32'h0001_0001);
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input int a, input logic [31:0] w);
        int b, h;
        b = int'((w >> (8 * a)) & 32'hFF);
        h = int'((w >> (16 * (a / 2))) & 32'hFFFF);
        case (f3)
            3'd0:    return (b >= 128)   ? 32'(b - 256)   : 32'(b);
            3'd4:    return 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic exp_t idle_rec();
        exp_t e;
        e = '0;
        return e;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        exp_t e;
        if (cmp_en && expq.size() > 0) begin
            e = expq.pop_front();
            chk("stall_M", 32'(stall_M), 32'(e.stall));
            chk("dbus_req", 32'(bus.dbus_req), 32'(e.req));
            chk("bus_err_M", 32'(bus_err_M), 32'(e.err));
`ifdef MISALIGN_TRAP_EN
            chk("misalign_M", 32'(misalign_M), 32'(e.mis));
`endif
            if (e.req) begin
                chk("dbus_we", 32'(bus.dbus_we), 32'(e.we));
                chk("dbus_addr", bus.dbus_addr, e.addr);
                chk("dbus_be", 32'(bus.dbus_be), 32'(e.be));
                chk("dbus_wdata", bus.dbus_wdata, e.wdata);
                req_cycles++;
                last_addr  = bus.dbus_addr;
                last_be    = bus.dbus_be;
                last_wdata = bus.dbus_wdata;
            end
            if (e.done) begin
                chk("read_data_M", read_data_M, e.rd);
                last_rd = read_data_M;
            end
            if (stall_M)   stall_hi++;
            if (bus_err_M) err_pulses++;
`ifdef MISALIGN_TRAP_EN
            if (misalign_M) mis_pulses++;
`endif
        end
    end

    task automatic clear_stats();
        req_cycles = 0; stall_hi = 0; err_pulses = 0; mis_pulses = 0;
        last_addr = '0; last_wdata = '0; last_rd = 32'hXXXX_XXXX; last_be = '0;
    endtask

    // One access: g = REQ cycle index carrying gnt, r = WAIT cycle index
    // carrying rvalid; indices >= T never arrive and end in a timeout.
    task automatic do_txn(input bit rd_, input bit wr_, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rw, input int g, input int r,
                          input int gap);
        exp_t e;
        bit   timeout, mis;
        int   alo;
        alo = int'(a & 32'h3);
        mem_read_M = rd_; mem_write_M = wr_; funct3_M = f3;
        addr_M = a; write_data_M = wd; gnt = 1'b0; rvalid = 1'b0;
        e = idle_rec(); e.stall = 1'b1; expq.push_back(e);
        @(posedge clk); #1;
        timeout = 1'b0;
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = ((f3 % 4 == 1) && (alo % 2 == 1)) || ((f3 % 4 == 2) && (alo != 0));
`endif
        if (!mis) begin
            for (int i = 0; i < 100; i++) begin
                gnt = (i == g);
                e = idle_rec(); e.stall = 1'b1; e.req = 1'b1; e.we = wr_;
                e.addr = a & ~32'h3; e.be = exp_be(f3, alo); e.wdata = exp_wdata(f3, wd);
                expq.push_back(e);
                @(posedge clk); #1;
                gnt = 1'b0;
                if (i == g) break;
                if (i == T - 1) begin timeout = 1'b1; break; end
            end
            if (!timeout) begin
                for (int j = 0; j < 100; j++) begin
                    rvalid = (j == r);
                    rdata  = (j == r) ? rw : $urandom;
                    e = idle_rec(); e.stall = 1'b1; expq.push_back(e);
                    @(posedge clk); #1;
                    rvalid = 1'b0;
                    if (j == r) break;
                    if (j == T - 1) begin timeout = 1'b1; break; end
                end
            end
        end
        mem_read_M = 1'b0; mem_write_M = 1'b0;
        e = idle_rec(); e.done = 1'b1; e.err = timeout; e.mis = mis;
        e.rd = (timeout || mis || wr_) ? 32'd0 : exp_load(f3, alo, rw);
        expq.push_back(e);
        @(posedge clk); #1;
        for (int k = 0; k < gap; k++) begin
            expq.push_back(idle_rec());
            @(posedge clk); #1;
        end
    endtask

    function automatic int rand_delay();
        if ($urandom_range(0, 9) < 8) return int'($urandom_range(0, 3));
        return int'($urandom_range(0, 10));
    endfunction

    initial begin
        logic [2:0] f3_tab [5];
        f3_tab[0] = F3_LB; f3_tab[1] = F3_LH; f3_tab[2] = F3_LW;
        f3_tab[3] = F3_LBU; f3_tab[4] = F3_LHU;

        reset = 1'b1;
        mem_read_M = 1'b0; mem_write_M = 1'b0; funct3_M = 3'd0;
        addr_M = '0; write_data_M = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        clear_stats();
        #12;
        chk("rst_stall", 32'(stall_M), 32'd0);
        chk("rst_req", 32'(bus.dbus_req), 32'd0);
        chk("rst_we", 32'(bus.dbus_we), 32'd0);
        chk("rst_addr", bus.dbus_addr, 32'd0);
        chk("rst_be", 32'(bus.dbus_be), 32'd0);
        chk("rst_wdata", bus.dbus_wdata, 32'd0);
        chk("rst_rdata", read_data_M, 32'd0);
        chk("rst_err", 32'(bus_err_M), 32'd0);
`ifdef MISALIGN_TRAP_EN
        chk("rst_mis", 32'(misalign_M), 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        cmp_en = 1'b1;

        // SW, fastest handshake
        clear_stats();
        do_txn(1'b0, 1'b1, F3_SW, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0, 1);
        chk("sw_addr", last_addr, 32'h100);
        chk("sw_be", 32'(last_be), 32'hF);
        chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("sw_stall_cycles", 32'(stall_hi), 32'd3);
        chk("sw_req_cycles", 32'(req_cycles), 32'd1);

        clear_stats();
        do_txn(1'b1, 1'b0, F3_LB, 32'h203, 32'h0, 32'h80FF_0000, 0, 0, 0);
        chk("lb_be", 32'(last_be), 32'h8);
        chk("lb_data", last_rd, 32'hFFFF_FF80);
        clear_stats();
        do_txn(1'b1, 1'b0, F3_LBU, 32'h203, 32'h0, 32'h80FF_0000, 0, 0, 0);
        chk("lbu_data", last_rd, 32'h0000_0080);

        clear_stats();
        do_txn(1'b0, 1'b1, F3_SH, 32'h012, 32'h0000_ABCD, 32'h0, 0, 0, 0);
        chk("sh_be", 32'(last_be), 32'hC);
        chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
        clear_stats();
        do_txn(1'b1, 1'b0, F3_LH, 32'h012, 32'h0, 32'h7FFF_1234, 0, 0, 0);
        chk("lh_data", last_rd, 32'h0000_7FFF);

        // delayed grant and response
        clear_stats();
        do_txn(1'b1, 1'b0, F3_LW, 32'h40, 32'h0, 32'h1234_5678, 5, 3, 1);
        chk("slow_req_cycles", 32'(req_cycles), 32'd6);
        chk("slow_stall_cycles", 32'(stall_hi), 32'd11);
        chk("slow_data", last_rd, 32'h1234_5678);

        // response never arrives
        clear_stats();
        do_txn(1'b1, 1'b0, F3_LW, 32'h80, 32'h0, 32'h5555_AAAA, 0, 99, 1);
        chk("to_err_pulses", 32'(err_pulses), 32'd1);
        chk("to_data", last_rd, 32'd0);
        // grant never arrives
        clear_stats();
        do_txn(1'b0, 1'b1, F3_SW, 32'h84, 32'h1111_2222, 32'h0, 99, 0, 1);
        chk("to_req_err_pulses", 32'(err_pulses), 32'd1);
        chk("to_req_cycles", 32'(req_cycles), 32'(T));

        // reset in REQ drops the request immediately
        cmp_en = 1'b0;
        mem_read_M = 1'b1; funct3_M = F3_LW; addr_M = 32'h300;
        @(posedge clk); #3;
        chk("pre_rst_req", 32'(bus.dbus_req), 32'd1);
        reset = 1'b1; mem_read_M = 1'b0;
        #1;
        chk("rst_req_drop", 32'(bus.dbus_req), 32'd0);
        chk("rst_req_stall", 32'(stall_M), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        // reset in WAIT, then a stale response
        mem_read_M = 1'b1;
        @(posedge clk); #1;
        gnt = 1'b1;
        @(posedge clk); #1;
        gnt = 1'b0;
        chk("wait_stall", 32'(stall_M), 32'd1);
        #2;
        reset = 1'b1; mem_read_M = 1'b0;
        #1;
        chk("rst_wait_stall", 32'(stall_M), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        rvalid = 1'b1; rdata = 32'hCAFE_BABE;
        @(posedge clk); #1;
        rvalid = 1'b0;
        @(posedge clk); #1;
        chk("late_rvalid_data", read_data_M, 32'd0);
        chk("late_rvalid_stall", 32'(stall_M), 32'd0);
        chk("late_rvalid_req", 32'(bus.dbus_req), 32'd0);
        cmp_en = 1'b1;

`ifdef MISALIGN_TRAP_EN
        clear_stats();
        do_txn(1'b1, 1'b0, F3_LW, 32'h101, 32'h0, 32'h0, 0, 0, 1);
        chk("mis_req_cycles", 32'(req_cycles), 32'd0);
        chk("mis_pulses", 32'(mis_pulses), 32'd1);
        chk("mis_stall_cycles", 32'(stall_hi), 32'd1);
        chk("mis_data", last_rd, 32'd0);
`endif

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            bit         wr, rd;
            logic [2:0] f3;
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            f3 = wr ? 3'($urandom_range(0, 2)) : f3_tab[$urandom_range(0, 4)];
            do_txn(rd, wr, f3, $urandom, $urandom, $urandom,
                   rand_delay(), rand_delay(), int'($urandom_range(0, 2)));
        end

        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL expq_drain actual=%0d required=0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
